sync_data_fifo: RTL and testbench
=================================

# sync_data_fifo

Parametrised synchronous FIFO, successor to the single-entry data buffer. It decouples pipeline stages and bus ports inside the core, with configurable width and depth and first-word-fall-through read data. It adds an occupancy count, a programmable almost-full flag, a synchronous flush, and overflow/underflow pulses that the single-entry buffer lacks.

## Interface
- DataWidth, 64, width of each entry
- Depth, 4, number of entries; power of two, ≥ 2
- AlmostFullLevel, Depth-1, AlmostFull asserts when Count ≥ this value; range 1..Depth
- Clk  input  1  sole clock, rising edge
- Rst  input  1  reset, asynchronous, active-high
- Flush  input  1  synchronous clear of all contents
- WData  input  DataWidth  write data
- WInc  input  1  write request
- WFull  output  1  no free entry
- AlmostFull  output  1  Count ≥ AlmostFullLevel
- RData  output  DataWidth  head entry, valid whenever REmpty = 0
- RInc  input  1  read request (pop head)
- REmpty  output  1  no stored entry
- Count  output  $clog2(Depth+1)  current occupancy, 0..Depth
- Overflow  output  1  one-cycle pulse: WInc while WFull
- Underflow  output  1  one-cycle pulse: RInc while REmpty

## Operation
- Write accepted iff WInc && !WFull. Accepted data goes to the entry at the write pointer, and the pointer advances.
- Read accepted iff RInc && !REmpty. The read pointer advances, and RData shows the next entry (first-word fall-through, no read latency).
- Rejected requests change no state and raise Overflow/Underflow on the next cycle for one cycle only.
- Simultaneous accepted read and write: Count is unchanged and both pointers advance.
  - Full with WInc && RInc: only the read is accepted. The write is rejected and Overflow pulses.
  - Empty with WInc && RInc: only the write is accepted. Underflow pulses.
- Pointers are log2(Depth)+1 bits, with the MSB as the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Wrap from Depth-1 to 0 is natural modulo arithmetic.
- Count is a registered counter (+1 on write only, −1 on read only), not derived from the pointers. It must always equal wptr − rptr modulo 2·Depth.
- Flush has priority over WInc and RInc in the same cycle. It zeroes both pointers and Count, and suppresses Overflow and Underflow that cycle. Storage contents are left unchanged.

## Timing
- Reset (Rst = 1, asynchronous):
  - pointers = 0, Count = 0, storage = 0
  - WFull = 0, AlmostFull = 0 (AlmostFullLevel ≥ 1), REmpty = 1, RData = 0
  - Overflow = 0, Underflow = 0
- Reset may assert mid-transfer. All state clears immediately, and in-flight data is discarded.
- All flags and Count are registered, or decoded only from registers. They update on the Clk edge that accepts the request, so there are no combinational paths from WInc/RInc to the outputs.
- Latency:
  - Write to REmpty deassert: 1 cycle.
  - Write into an empty FIFO is visible on RData in the cycle after acceptance.
  - Read to WFull deassert: 1 cycle.
- Sustained throughput is one write and one read per cycle when the FIFO is neither full nor empty.

## Structure
- A shared package holds:
  - pointer-width and count-width constants derived from Depth
  - a function returning the flag vector from Count
- One sub-module, sync_data_fifo_mem: a DataWidth × Depth register array with one write port and an asynchronous read port addressed by rptr low bits, reset to zero.
- The top level owns the pointers, Count, flags and error pulses.

## Test plan
- Reset then idle: REmpty = 1, WFull = 0, Count = 0, RData = 0, no pulses.
- Depth = 4, write 0xA1..0xA4 on consecutive cycles:
  - Count steps 1..4, AlmostFull at Count = 3, WFull after the 4th write.
  - A 5th WInc gives Overflow = 1 for one cycle, and Count stays 4.
- Drain the full FIFO: RData reads 0xA1, 0xA2, 0xA3, 0xA4 in order. REmpty = 1 after the 4th read, and an extra RInc gives Underflow = 1.
- Simultaneous WInc/RInc at Count = 2, for 10 cycles through pointer wrap:
  - Count stays 2 and the data order is preserved.
  - Repeating at full gives only a pop plus Overflow; repeating at empty gives only a push plus Underflow.
- Flush with WInc and RInc asserted at Count = 3: Count = 0, REmpty = 1, no pulses. The next write of 0x55 appears on RData one cycle later.
- Rst asserted asynchronously between edges with Count = 2: outputs return to reset values immediately.

Source files
------------

// File: rtl/sync_data_fifo_pkg.sv
// Shared constants, flag types and helper functions for the synchronous data FIFO.
package sync_data_fifo_pkg;

    // Occupancy flags decoded from the registered entry count.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
    } fifo_flags_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Count width: must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Flag vector for a given occupancy.
    function automatic fifo_flags_t count_flags(input logic [31:0] count,
                                                input logic [31:0] depth,
                                                input logic [31:0] af_level);
        fifo_flags_t flags;
        flags.full        = (count == depth);
        flags.almost_full = (count >= af_level);
        flags.empty       = (count == 32'd0);
        return flags;
    endfunction

endpackage

// File: rtl/sync_data_fifo_mem.sv
// Register-array storage for the FIFO: one write port, one asynchronous read port.
module sync_data_fifo_mem #(
    parameter int DataWidth = 64,
    parameter int Depth     = 4,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 WEn,
    input  logic [AddrWidth-1:0] WAddr,
    input  logic [DataWidth-1:0] WData,
    input  logic [AddrWidth-1:0] RAddr,
    output logic [DataWidth-1:0] RData
);

    logic [DataWidth-1:0] mem_r [Depth];

    // Storage array: cleared on reset, one entry written per accepted push.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= {DataWidth{1'b0}};
            end
        end else if (WEn) begin
            mem_r[WAddr] <= WData;
        end
    end

    // Head entry is presented without latency (first-word fall-through).
    assign RData = mem_r[RAddr];

endmodule

// File: rtl/sync_data_fifo.sv
// Parametrised synchronous FIFO with occupancy count, almost-full flag,
// synchronous flush and one-cycle overflow/underflow pulses.
module sync_data_fifo
    import sync_data_fifo_pkg::*;
#(
    parameter int DataWidth       = 64,
    parameter int Depth           = 4,
    parameter int AlmostFullLevel = Depth - 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Flush,
    input  logic [DataWidth-1:0]         WData,
    input  logic                         WInc,
    output logic                         WFull,
    output logic                         AlmostFull,
    output logic [DataWidth-1:0]         RData,
    input  logic                         RInc,
    output logic                         REmpty,
    output logic [$clog2(Depth+1)-1:0]   Count,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int PtrWidth   = ptr_width(Depth);
    localparam int AddrWidth  = PtrWidth - 1;
    localparam int CountWidth = count_width(Depth);

    logic [PtrWidth-1:0]   wptr_r,  wptr_next_s;
    logic [PtrWidth-1:0]   rptr_r,  rptr_next_s;
    logic [CountWidth-1:0] count_r, count_next_s;
    logic                  full_r,  full_next_s;
    logic                  afull_r, afull_next_s;
    logic                  empty_r, empty_next_s;
    logic                  overflow_r,  overflow_next_s;
    logic                  underflow_r, underflow_next_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  ptr_full_next_s;
    logic                  ptr_empty_next_s;
    fifo_flags_t           flags_next_s;

    // Request qualification; flush takes priority over both ports.
    always_comb begin
        wr_accept_s = 1'b0;
        rd_accept_s = 1'b0;
        if (Flush) begin
            wr_accept_s = 1'b0;
            rd_accept_s = 1'b0;
        end else begin
            wr_accept_s = WInc && !full_r;
            rd_accept_s = RInc && !empty_r;
        end
    end

    // Next-state for pointers, count, flags and error pulses.
    always_comb begin
        wptr_next_s      = wptr_r;
        rptr_next_s      = rptr_r;
        count_next_s     = count_r;
        overflow_next_s  = 1'b0;
        underflow_next_s = 1'b0;
        if (Flush) begin
            wptr_next_s  = {PtrWidth{1'b0}};
            rptr_next_s  = {PtrWidth{1'b0}};
            count_next_s = {CountWidth{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wptr_next_s = wptr_r + PtrWidth'(1);
            end else begin
                wptr_next_s = wptr_r;
            end
            if (rd_accept_s) begin
                rptr_next_s = rptr_r + PtrWidth'(1);
            end else begin
                rptr_next_s = rptr_r;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   count_next_s = count_r + CountWidth'(1);
                2'b01:   count_next_s = count_r - CountWidth'(1);
                default: count_next_s = count_r;
            endcase
            overflow_next_s  = WInc && full_r;
            underflow_next_s = RInc && empty_r;
        end

        flags_next_s = count_flags(32'(count_next_s), 32'(Depth), 32'(AlmostFullLevel));
        ptr_full_next_s  = (wptr_next_s[AddrWidth-1:0] == rptr_next_s[AddrWidth-1:0]) &&
                           (wptr_next_s[PtrWidth-1]    != rptr_next_s[PtrWidth-1]);
        ptr_empty_next_s = (wptr_next_s == rptr_next_s);
        // Either view of occupancy blocks a transfer, so a disturbed count
        // can never walk the pointers past each other.
        full_next_s  = flags_next_s.full  || ptr_full_next_s;
        empty_next_s = flags_next_s.empty || ptr_empty_next_s;
        afull_next_s = flags_next_s.almost_full;
    end

    // State registers: pointers, count, registered flags and pulses.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr_r      <= {PtrWidth{1'b0}};
            rptr_r      <= {PtrWidth{1'b0}};
            count_r     <= {CountWidth{1'b0}};
            full_r      <= 1'b0;
            afull_r     <= 1'b0;
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wptr_r      <= wptr_next_s;
            rptr_r      <= rptr_next_s;
            count_r     <= count_next_s;
            full_r      <= full_next_s;
            afull_r     <= afull_next_s;
            empty_r     <= empty_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    sync_data_fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .AddrWidth (AddrWidth)
    ) u_mem (
        .Clk   (Clk),
        .Rst   (Rst),
        .WEn   (wr_accept_s),
        .WAddr (wptr_r[AddrWidth-1:0]),
        .WData (WData),
        .RAddr (rptr_r[AddrWidth-1:0]),
        .RData (RData)
    );

    assign WFull      = full_r;
    assign AlmostFull = afull_r;
    assign REmpty     = empty_r;
    assign Count      = count_r;
    assign Overflow   = overflow_r;
    assign Underflow  = underflow_r;

endmodule

// File: tb/tb_sync_data_fifo.sv
// Self-checking bench for sync_data_fifo (Depth 4, AlmostFullLevel 3):
// vector table for flags/count plus a data scoreboard for RData ordering.
module tb_sync_data_fifo;

    logic        Clk;
    logic        Rst;
    logic        Flush;
    logic [63:0] WData;
    logic        WInc;
    logic        WFull;
    logic        AlmostFull;
    logic [63:0] RData;
    logic        RInc;
    logic        REmpty;
    logic [2:0]  Count;
    logic        Overflow;
    logic        Underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb[$];

    typedef struct {
        string       name;
        logic        flush;
        logic        winc;
        logic        rinc;
        logic [63:0] wdata;
        logic [2:0]  count;
        logic        full;
        logic        af;
        logic        empty;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs[$];

    sync_data_fifo #(
        .DataWidth       (64),
        .Depth           (4),
        .AlmostFullLevel (3)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Flush      (Flush),
        .WData      (WData),
        .WInc       (WInc),
        .WFull      (WFull),
        .AlmostFull (AlmostFull),
        .RData      (RData),
        .RInc       (RInc),
        .REmpty     (REmpty),
        .Count      (Count),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic f, input logic w, input logic r,
                                input logic [63:0] d, input logic [2:0] cnt, input logic full,
                                input logic af, input logic empty, input logic ovf, input logic udf);
        vec_t v;
        v.name = name; v.flush = f; v.winc = w; v.rinc = r; v.wdata = d;
        v.count = cnt; v.full = full; v.af = af; v.empty = empty; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    // Apply one vector (called at a falling edge), check outputs 1 time unit after the rising edge.
    task automatic step(input vec_t v);
        bit was_full;
        bit was_empty;
        Flush = v.flush;
        WInc  = v.winc;
        RInc  = v.rinc;
        WData = v.wdata;
        if (sb.size() > 0) check({v.name, " rdata"}, RData, sb[0]);
        was_full  = (sb.size() == 4);
        was_empty = (sb.size() == 0);
        if (v.flush) begin
            sb.delete();
        end else begin
            if (v.rinc && !was_empty) void'(sb.pop_front());
            if (v.winc && !was_full)  sb.push_back(v.wdata);
        end
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        WInc  = 1'b0;
        RInc  = 1'b0;
        check({v.name, " count"},      64'(Count),      64'(v.count));
        check({v.name, " model_count"}, 64'(Count),     64'(sb.size()));
        check({v.name, " wfull"},      64'(WFull),      64'(v.full));
        check({v.name, " almostfull"}, 64'(AlmostFull), 64'(v.af));
        check({v.name, " rempty"},     64'(REmpty),     64'(v.empty));
        check({v.name, " overflow"},   64'(Overflow),   64'(v.ovf));
        check({v.name, " underflow"},  64'(Underflow),  64'(v.udf));
        @(negedge Clk);
    endtask

    task automatic check_reset_state(input string name);
        check({name, " count"},     64'(Count),      64'd0);
        check({name, " wfull"},     64'(WFull),      64'd0);
        check({name, " almostfull"},64'(AlmostFull), 64'd0);
        check({name, " rempty"},    64'(REmpty),     64'd1);
        check({name, " rdata"},     RData,           64'd0);
        check({name, " overflow"},  64'(Overflow),   64'd0);
        check({name, " underflow"}, 64'(Underflow),  64'd0);
    endtask

    initial begin
        Rst   = 1'b1;
        Flush = 1'b0;
        WInc  = 1'b0;
        RInc  = 1'b0;
        WData = 64'd0;

        // Fill to full, overflow, drain, underflow.
        vecs.push_back(mk("wr1",   1'b0, 1'b1, 1'b0, 64'hA1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("wr2",   1'b0, 1'b1, 1'b0, 64'hA2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("wr3",   1'b0, 1'b1, 1'b0, 64'hA3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("wr4",   1'b0, 1'b1, 1'b0, 64'hA4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("wr5ov", 1'b0, 1'b1, 1'b0, 64'hA5, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("idle1", 1'b0, 1'b0, 1'b0, 64'h0,  3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("rd1",   1'b0, 1'b0, 1'b1, 64'h0,  3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("rd2",   1'b0, 1'b0, 1'b1, 64'h0,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("rd3",   1'b0, 1'b0, 1'b1, 64'h0,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("rd4",   1'b0, 1'b0, 1'b1, 64'h0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("rd5un", 1'b0, 1'b0, 1'b1, 64'h0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("idle2", 1'b0, 1'b0, 1'b0, 64'h0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        // Steady state at Count = 2 through pointer wrap.
        vecs.push_back(mk("pre1",  1'b0, 1'b1, 1'b0, 64'hB0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("pre2",  1'b0, 1'b1, 1'b0, 64'hB1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk("wr_rd_mid", 1'b0, 1'b1, 1'b1, 64'hB2 + 64'(i), 3'd2,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        // Simultaneous at full, then at empty.
        vecs.push_back(mk("fill3",   1'b0, 1'b1, 1'b0, 64'hC0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("fill4",   1'b0, 1'b1, 1'b0, 64'hC1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("wr_rd_full", 1'b0, 1'b1, 1'b1, 64'hC2, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("drain1",  1'b0, 1'b0, 1'b1, 64'h0,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("drain2",  1'b0, 1'b0, 1'b1, 64'h0,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("drain3",  1'b0, 1'b0, 1'b1, 64'h0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("wr_rd_empty", 1'b0, 1'b1, 1'b1, 64'hD0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("drain4",  1'b0, 1'b0, 1'b1, 64'h0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        // Flush with both requests at Count = 3, then a write after flush.
        vecs.push_back(mk("fl_w1",   1'b0, 1'b1, 1'b0, 64'hE1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("fl_w2",   1'b0, 1'b1, 1'b0, 64'hE2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("fl_w3",   1'b0, 1'b1, 1'b0, 64'hE3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("flush",   1'b1, 1'b1, 1'b1, 64'hE4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("post55",  1'b0, 1'b1, 1'b0, 64'h55, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("post66",  1'b0, 1'b1, 1'b0, 64'h66, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset then idle.
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        check_reset_state("reset");
        @(negedge Clk);
        check_reset_state("reset_idle");

        foreach (vecs[i]) step(vecs[i]);

        // Flushed entry must be gone: head after flush is 0x55.
        check("post_flush_head", RData, 64'h55);

        // Asynchronous reset between edges with two entries stored.
        #2;
        Rst = 1'b1;
        #1;
        sb.delete();
        check_reset_state("async_rst");
        @(negedge Clk);
        Rst = 1'b0;
        check_reset_state("async_rst_release");
        step(mk("after_rst", 1'b0, 1'b1, 1'b0, 64'h77, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("after_rst_head", RData, 64'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
